// File: rtl/keystream_sched_pkg.sv
// Shared ChaCha types for the keystream scheduler: word and 4x4 block state,
// plus the scheduler's FSM encoding.
package keystream_sched_pkg;

  typedef logic [31:0] word_t;
  typedef word_t [3:0][3:0] block_t;

  localparam int WORDS_PER_BLK = 16;
  localparam int IDX_W = $clog2(WORDS_PER_BLK);

  typedef enum logic [1:0] {
    IDLE,
    FILL,
    STREAM,
    DRAIN
  } state_t;

endpackage

// File: rtl/keystream_sched_blk_word_mux.sv
// Selects keystream word idx from a finished block; word 0 is block[3][3],
// word 15 is block[0][0].
module blk_word_mux
  import keystream_sched_pkg::*;
(
  input  block_t           block,
  input  logic [IDX_W-1:0] idx,
  output word_t            word
);

  // Inverting each 2-bit index field is the same as 3 - field.
  assign word = block[~idx[3:2]][~idx[1:0]];

endmodule

// File: rtl/keystream_sched.sv
// Schedules ChaCha20 block-core launches and streams the resulting keystream
// words over a valid/ready port, prefetching the next block into one buffer.
module keystream_sched
  import keystream_sched_pkg::*;
#(
  parameter int NUM_BLK_W = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [31:0]          init_ctr,
  input  logic [NUM_BLK_W-1:0] num_blocks,
  output logic                 core_start,
  output logic [31:0]          core_ctr,
  input  logic                 core_done,
  input  block_t               core_block,
  output word_t                out_word,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic                 out_last,
  output logic                 busy,
  output logic                 done,
  output logic                 ctr_ovf
);

  state_t               state, next_state;
  logic [IDX_W-1:0]     k;
  block_t               active, pending;
  logic                 pend_valid;
  logic                 core_busy;
  logic                 zero_done;
  logic [NUM_BLK_W-1:0] left;
  logic                 take_done, hs, last_k, launch;
  word_t                mux_word;

  // A core_done only counts while a launch of this run is outstanding.
  assign take_done = core_done && core_busy;
  assign hs        = out_valid && out_ready;
  assign last_k    = (k == IDX_W'(WORDS_PER_BLK - 1));

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= next_state;
  end

  always_comb begin
    next_state = state;
    launch     = 1'b0;
    case (state)
      IDLE: begin
        if (start && (num_blocks != '0)) next_state = FILL;
      end
      FILL: begin
        launch = !core_busy && (left != '0);
        if (take_done) next_state = STREAM;
      end
      STREAM: begin
        // Prefetch only into an empty pending buffer so a result always has a home.
        launch = !core_busy && (left != '0) && !pend_valid;
        if (hs && last_k && !pend_valid && !take_done)
          next_state = ((left != '0) || core_busy) ? FILL : DRAIN;
      end
      default: next_state = IDLE;
    endcase
  end

  assign core_start = launch;
  assign out_valid  = (state == STREAM);
  assign out_last   = out_valid && last_k && !pend_valid && (left == '0) && !core_busy;
  assign busy       = (state == FILL) || (state == STREAM);
  assign done       = (state == DRAIN) || zero_done;
  assign out_word   = out_valid ? mux_word : '0;

  blk_word_mux u_mux (
    .block(active),
    .idx  (k),
    .word (mux_word)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      k          <= '0;
      active     <= '0;
      pending    <= '0;
      pend_valid <= 1'b0;
      core_busy  <= 1'b0;
      zero_done  <= 1'b0;
      left       <= '0;
      core_ctr   <= '0;
      ctr_ovf    <= 1'b0;
    end else begin
      zero_done <= (state == IDLE) && start && (num_blocks == '0);
      if ((state == IDLE) && start) begin
        ctr_ovf    <= 1'b0;
        core_ctr   <= init_ctr;
        left       <= num_blocks;
        k          <= '0;
        pend_valid <= 1'b0;
      end
      if (launch) begin
        left      <= left - 1'b1;
        core_busy <= 1'b1;
      end
      // core_ctr advances only once the launched block is back, keeping it stable
      // for the core; a wrap past 0xFFFFFFFF truncates the run instead.
      if (take_done) begin
        core_busy <= 1'b0;
        if (left != '0) begin
          if (core_ctr == 32'hFFFF_FFFF) begin
            ctr_ovf <= 1'b1;
            left    <= '0;
          end else begin
            core_ctr <= core_ctr + 32'd1;
          end
        end
      end
      if ((state == FILL) && take_done) begin
        active <= core_block;
        k      <= '0;
      end else if (state == STREAM) begin
        if (hs && last_k) begin
          k <= '0;
          if (pend_valid) begin
            active     <= pending;
            pend_valid <= 1'b0;
          end else if (take_done) begin
            active <= core_block;
          end
        end else if (hs) begin
          k <= k + 1'b1;
        end
        if (take_done && !(hs && last_k)) begin
          pending    <= core_block;
          pend_valid <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_keystream_sched.sv
// Scoreboard bench for keystream_sched: a behavioural block core answers launches,
// a monitor pops expected words/counters as the DUT presents them.
module tb_keystream_sched;
  import keystream_sched_pkg::*;

  localparam int NBW = 16;

  logic           clk = 1'b0;
  logic           rst, start;
  logic [31:0]    init_ctr;
  logic [NBW-1:0] num_blocks;
  logic           core_start;
  logic [31:0]    core_ctr;
  logic           core_done = 1'b0;
  block_t         core_block = '0;
  word_t          out_word;
  logic           out_valid, out_last, busy, done, ctr_ovf;
  logic           out_ready = 1'b1;

  typedef struct packed {
    word_t word;
    logic  last;
  } exp_t;

  exp_t        exp_q[$];
  logic [31:0] ctr_q[$];
  exp_t        e_mon;
  int          checks = 0, errors = 0;
  int          core_lat = 3, lat_cnt = 0;
  logic [31:0] pend_ctr = '0;
  int          done_cnt = 0, gap_cnt = 0, hs_cnt = 0;
  logic        seen_word = 1'b0, prev_stall = 1'b0, prev_last = 1'b0;
  word_t       prev_word = '0;
  logic        rand_ready = 1'b0;
  int          cyc;

  keystream_sched #(.NUM_BLK_W(NBW)) dut (
    .clk(clk), .rst(rst), .start(start), .init_ctr(init_ctr), .num_blocks(num_blocks),
    .core_start(core_start), .core_ctr(core_ctr), .core_done(core_done), .core_block(core_block),
    .out_word(out_word), .out_valid(out_valid), .out_ready(out_ready), .out_last(out_last),
    .busy(busy), .done(done), .ctr_ovf(ctr_ovf)
  );

  always #5 clk = ~clk;

  // Block words encode their counter and row-major position i*4+j.
  function automatic block_t blk_of(input logic [31:0] ctr);
    block_t b;
    b = '0;
    for (int i = 0; i < 4; i++)
      for (int j = 0; j < 4; j++)
        b[i][j] = {ctr[27:0], 4'(i * 4 + j)};
    return b;
  endfunction

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", name, act, req);
    end
  endtask

  // Behavioural core: fixed latency, keeps counting through a reset.
  always @(negedge clk) begin
    core_done = 1'b0;
    if (lat_cnt > 0) begin
      lat_cnt--;
      if (lat_cnt == 0) begin
        core_done  = 1'b1;
        core_block = blk_of(pend_ctr);
      end
    end
    if (core_start) begin
      if (ctr_q.size() == 0) begin
        checks++;
        errors++;
        $display("[TB] FAIL unexpected_core_start: got ctr 0x%08h expected no launch", core_ctr);
      end else begin
        check_output("core_ctr", core_ctr, ctr_q.pop_front());
      end
      pend_ctr = core_ctr;
      lat_cnt  = core_lat;
    end
  end

  always @(negedge clk) begin
    if (!rst) begin
      if (done) done_cnt++;
      if (!busy) seen_word = 1'b0;
      else if (out_valid) seen_word = 1'b1;
      else if (seen_word) gap_cnt++;
      if (prev_stall) begin
        check_output("stall_valid", 32'(out_valid), 32'd1);
        check_output("stall_word", out_word, prev_word);
        check_output("stall_last", 32'(out_last), 32'(prev_last));
      end
      if (out_valid && out_ready) begin
        hs_cnt++;
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("[TB] FAIL extra_word: got 0x%08h expected no word", out_word);
        end else begin
          e_mon = exp_q.pop_front();
          check_output("out_word", out_word, e_mon.word);
          check_output("out_last", 32'(out_last), 32'(e_mon.last));
        end
      end
      prev_stall = out_valid && !out_ready;
      prev_word  = out_word;
      prev_last  = out_last;
    end else begin
      prev_stall = 1'b0;
    end
  end

  always @(posedge clk) begin
    #1;
    out_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
  end

  task automatic apply_stimulus(input logic [31:0] ctr0, input int n, input int n_exp, input int lat);
    exp_t        e;
    logic [31:0] c;
    core_lat = lat;
    for (int b = 0; b < n_exp; b++) begin
      c = ctr0 + 32'(b);
      ctr_q.push_back(c);
      for (int kk = 0; kk < 16; kk++) begin
        e.word = {c[27:0], 4'(15 - kk)};
        e.last = (b == n_exp - 1) && (kk == 15);
        exp_q.push_back(e);
      end
    end
    done_cnt = 0;
    gap_cnt  = 0;
    hs_cnt   = 0;
    @(posedge clk); #1;
    init_ctr   = ctr0;
    num_blocks = NBW'(n);
    start      = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_run(input string name, input logic exp_ovf);
    int n;
    n = 0;
    while (done_cnt == 0 && n < 3000) begin
      @(posedge clk);
      n++;
    end
    if (done_cnt == 0) begin
      checks++;
      errors++;
      $display("[TB] FAIL %s_timeout: got no done after %0d cycles, expected done", name, n);
    end
    repeat (4) @(posedge clk);
    #1;
    check_output({name, "_done_cnt"}, 32'(done_cnt), 32'd1);
    check_output({name, "_busy"}, 32'(busy), 32'd0);
    check_output({name, "_ctr_ovf"}, 32'(ctr_ovf), 32'(exp_ovf));
    check_output({name, "_words_left"}, 32'(exp_q.size()), 32'd0);
    check_output({name, "_launches_left"}, 32'(ctr_q.size()), 32'd0);
    check_output({name, "_gaps"}, 32'(gap_cnt), 32'd0);
  endtask

  task automatic check_idle(input string name);
    check_output({name, "_out_valid"}, 32'(out_valid), 32'd0);
    check_output({name, "_out_last"}, 32'(out_last), 32'd0);
    check_output({name, "_busy"}, 32'(busy), 32'd0);
    check_output({name, "_done"}, 32'(done), 32'd0);
    check_output({name, "_core_start"}, 32'(core_start), 32'd0);
    check_output({name, "_out_word"}, out_word, 32'd0);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; init_ctr = '0; num_blocks = '0;
    repeat (3) @(posedge clk);
    #1;
    check_idle("reset");
    check_output("reset_ctr_ovf", 32'(ctr_ovf), 32'd0);
    check_output("reset_core_ctr", core_ctr, 32'd0);
    rst = 1'b0;

    apply_stimulus(32'd5, 1, 1, 3);     wait_run("one_blk", 1'b0);
    apply_stimulus(32'd5, 3, 3, 10);    wait_run("three_blk", 1'b0);
    // Latency 15 lands block 1's core_done on block 0's word-15 handshake.
    apply_stimulus(32'd100, 2, 2, 15);  wait_run("fwd", 1'b0);

    rand_ready = 1'b1;
    apply_stimulus(32'h20, 2, 2, 2);    wait_run("stall", 1'b0);
    rand_ready = 1'b0;

    apply_stimulus(32'hFFFF_FFFE, 4, 2, 3); wait_run("wrap", 1'b1);
    apply_stimulus(32'd9, 1, 1, 3);     wait_run("ovf_clr", 1'b0);

    apply_stimulus(32'h30, 2, 2, 4);
    repeat (8) @(posedge clk);
    #1;
    init_ctr = 32'h999; num_blocks = NBW'(5); start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    wait_run("busy_start", 1'b0);

    done_cnt = 0;
    @(posedge clk); #1;
    num_blocks = '0; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    @(negedge clk);
    check_output("zero_done", 32'(done), 32'd1);
    check_output("zero_busy", 32'(busy), 32'd0);
    @(negedge clk);
    check_output("zero_done_end", 32'(done), 32'd0);
    check_output("zero_out_valid", 32'(out_valid), 32'd0);

    apply_stimulus(32'h40, 3, 3, 6);
    cyc = 0;
    while (hs_cnt < 20 && cyc < 500) begin
      @(posedge clk);
      cyc++;
    end
    check_output("abort_reached_blk1", 32'(hs_cnt >= 20), 32'd1);
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    exp_q.delete();
    ctr_q.delete();
    check_idle("abort");
    check_output("abort_core_ctr", core_ctr, 32'd0);
    done_cnt = 0;
    repeat (30) @(posedge clk);
    #1;
    check_idle("stale");
    check_output("stale_done_cnt", 32'(done_cnt), 32'd0);
    apply_stimulus(32'd7, 1, 1, 3);     wait_run("post_rst", 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/keystream_sched.md
KEYSTREAM_SCHED -- requirements
Module: keystream_sched

Interface
REQ-001 SHALL have parameter NUM_BLK_W, default 16, width of the block-count request.
REQ-002 SHALL have port clk, input, 1, system clock; all state updates on its rising edge.
REQ-003 SHALL have port rst, input, 1, reset: synchronous, active-high.
REQ-004 SHALL have port start, input, 1, one-cycle request to begin a run; ignored unless idle.
REQ-005 SHALL have port init_ctr, input, 32, ChaCha20 block counter of the first block; sampled on accepted start.
REQ-006 SHALL have port num_blocks, input, NUM_BLK_W, blocks to emit; sampled on accepted start.
REQ-007 SHALL have port core_start, output, 1, one-cycle pulse launching the block core.
REQ-008 SHALL have port core_ctr, output, 32, counter for the launched block; stable from core_start until core_done.
REQ-009 SHALL have port core_done, input, 1, one-cycle pulse: core_block holds a valid result.
REQ-010 SHALL have port core_block, input, word_t [3:0][3:0], finished 4x4 state from the core.
REQ-011 SHALL have port out_word, output, word_t, current keystream word.
REQ-012 SHALL have ports out_valid (output, 1) and out_ready (input, 1): valid/ready handshake for out_word.
REQ-013 SHALL have port out_last, output, 1, high with the final word of the run.
REQ-014 SHALL have ports busy (output, 1), high from accepted start to run end, and done (output, 1), one-cycle pulse at run end.
REQ-015 SHALL have port ctr_ovf, output, 1, sticky: run truncated by counter wrap; cleared by next accepted start.

Function
REQ-016 SHALL implement FSM IDLE, FILL, STREAM, DRAIN. IDLE->FILL on start with num_blocks!=0; start with num_blocks==0 SHALL pulse done next cycle, stay IDLE.
REQ-017 FILL: issue core_start once, wait core_done, capture core_block into active buffer, go to STREAM.
REQ-018 STREAM: present word k=0..15 of active buffer as block[3-k[3:2]][3-k[1:0]]; k advances only on out_valid&&out_ready.
REQ-019 out_valid SHALL be high throughout STREAM; out_word/out_last SHALL hold stable while out_valid&&!out_ready.
REQ-020 Prefetch: in STREAM, if blocks remain unlaunched and the core is idle, SHALL pulse core_start for next counter; result SHALL go to a single pending buffer.
REQ-021 On handshake of k=15: if pending valid, swap into active, k=0, no bubble; else if blocks remain, go to FILL-wait (out_valid low) until core_done; else DRAIN.
REQ-022 core_done arriving same cycle as k=15 handshake SHALL be forwarded directly to active with no lost block.
REQ-023 DRAIN: pulse done, drop busy, return to IDLE next cycle.
REQ-024 core_ctr SHALL increment by 1 per launched block, modulo 2^32.
REQ-025 If a block is to be launched with counter 0 after a block at 0xFFFFFFFF, SHALL not launch it, set ctr_ovf, treat that block as the last (out_last on its word 15).
REQ-026 out_last SHALL be high only on word 15 of the final emitted block.
REQ-027 start while busy SHALL be ignored with no effect.
REQ-028 core_done with no launch outstanding SHALL be ignored.

Reset
REQ-029 rst SHALL force IDLE, k=0, pending invalid; core_start, out_valid, out_last, busy, done, ctr_ovf=0; out_word=0; core_ctr=0.
REQ-030 rst mid-run SHALL abort immediately; a later core_done from the aborted launch SHALL be ignored.

Structure
REQ-031 word_t (32-bit) and the 4x4 block type SHALL come from the shared ChaCha package; WORDS_PER_BLK=16 SHALL be a package constant.
REQ-032 Word indexing/output mux SHALL be one sub-module, blk_word_mux (block + 4-bit index -> word).

Verification
REQ-033 init_ctr=5, num_blocks=1, out_ready=1 -> one core_start with core_ctr=5; 16 words block[3][3],block[3][2]..block[0][0]; out_last on 16th; done pulse.
REQ-034 num_blocks=3, core latency 10, out_ready=1 -> core_ctr 5,6,7; 48 contiguous words, no out_valid gap after block 0; one done.
REQ-035 out_ready toggled 1-0 random -> out_word stable while stalled; 16 distinct words in order; no drop/duplicate.
REQ-036 init_ctr=0xFFFFFFFE, num_blocks=4 -> blocks at 0xFFFFFFFE, 0xFFFFFFFF only; 32 words; ctr_ovf=1; out_last on word 32.
REQ-037 rst asserted mid-block 2, then stale core_done -> all outputs reset values, stay IDLE; next start runs cleanly.
REQ-038 num_blocks=0 start -> no core_start, no out_valid, done pulse next cycle; start while busy -> ignored.
